drp_sample_responder: RTL
=========================

DRP_SAMPLE_RESPONDER -- requirements
Module: drp_sample_responder

Interface
REQ-001 Parameter CONV_PERIOD, default 64: clock cycles between successive conversion completions (legal range 8..1023).
REQ-002 Parameter DRDY_LATENCY, default 2: cycles from accepted den_in to drdy_out (legal range 1..15).
REQ-003 clk  input  1  the single clock; all logic rising-edge.
REQ-004 clr_n  input  1  asynchronous, active-low reset.
REQ-005 den_in  input  1  DRP transaction strobe, one-cycle pulse.
REQ-006 daddr_in  input  7  DRP register address, sampled with den_in.
REQ-007 dwe_in  input  1  DRP write enable, sampled with den_in.
REQ-008 di_in  input  16  DRP write data, sampled with den_in.
REQ-009 do_out  output  16  DRP read data, valid only while drdy_out=1.
REQ-010 drdy_out  output  1  one-cycle transaction completion pulse.
REQ-011 eoc_out  output  1  one-cycle end-of-conversion pulse.
REQ-012 channel_out  output  5  channel converted by the most recent eoc_out (0x10 or 0x11).
REQ-013 busy_out  output  1  high while a DRP transaction is outstanding.
REQ-014 aux0_code  input  12  switch-channel sample source.
REQ-015 aux1_code  input  12  feed-channel sample source.

Function
REQ-016 Conversion timer counts 0..CONV_PERIOD-1 while the sequencer is enabled, then wraps to 0; eoc_out pulses for 1 cycle on the wrap cycle.
REQ-017 On each eoc_out, the current channel's code is captured: ch 0x10 stores {aux0_code,4'h0} in REG10; ch 0x11 stores {aux1_code,4'h0} in REG11; channel_out updates in the same cycle.
REQ-018 The channel alternates 0x10, 0x11, 0x10, ... starting at 0x10 after reset, unless the channel is held (REQ-027).
REQ-019 DRP FSM states: IDLE, WAIT, RESP.
REQ-020 IDLE + den_in=1 -> WAIT; latch address, dwe, di; snapshot read data at acceptance; load the latency counter with DRDY_LATENCY-1; busy_out=1.
REQ-021 WAIT decrements the counter; at 0 -> RESP. RESP drives drdy_out=1 and do_out for exactly 1 cycle, then -> IDLE with busy_out=0.
REQ-022 Total latency: drdy_out is asserted exactly DRDY_LATENCY+1 cycles after the den_in cycle.
REQ-023 den_in while busy_out=1 is ignored: no queueing, no second drdy_out.
REQ-024 Read map: 0x10 -> REG10; 0x11 -> REG11; 0x41 -> {14'h0, hold, seq_en}; all other addresses -> 16'h0000.
REQ-025 If a conversion updates a register in the same cycle as den_in reads it, the read returns the pre-update value.
REQ-026 do_out=16'h0000 whenever drdy_out=0.
REQ-027 Register 0x41: bit0 seq_en (1 = timer runs; 0 = timer frozen at its current count, no eoc_out); bit1 hold (1 = channel stays at its current value instead of alternating).
REQ-028 A write transaction always completes with one drdy_out; do_out=16'h0000 on write completion.

Reset
REQ-029 clr_n low asynchronously forces: FSM IDLE, drdy_out=0, do_out=0, busy_out=0, eoc_out=0, channel_out=5'h10, timer=0, REG10=REG11=0, seq_en=1, hold=0.
REQ-030 Reset asserted mid-transaction aborts it; no drdy_out is issued for that transaction after release.
REQ-031 After clr_n deasserts, the first eoc_out occurs CONV_PERIOD cycles after the first active clock edge.

Configuration
REQ-032 Macro DRP_SAMPLE_RESPONDER_WRITE_EN: when defined, DRP writes to 0x41 update seq_en/hold from di_in[1:0], and writes to any other address have no effect.
REQ-033 When DRP_SAMPLE_RESPONDER_WRITE_EN is undefined, every write has no effect and seq_en/hold remain at their reset values; drdy_out is still returned per REQ-028.

Verification
REQ-034 aux0_code=12'hABC, aux1_code=12'h123, defaults: first eoc_out at cycle 64 with channel_out=0x10, second at cycle 128 with 0x11; then read 0x10 -> 16'hABC0, read 0x11 -> 16'h1230.
REQ-035 den_in at cycle N, daddr_in=0x10 -> drdy_out only at N+3; den_in pulses at N+1 and N+2 produce no extra drdy_out.
REQ-036 Read 0x10 issued on the same cycle as the eoc_out that changes REG10 from 16'h1110 to 16'h2220 -> do_out=16'h1110.
REQ-037 With macro defined: write 0x41 = 16'h0000 -> no eoc_out for 500 cycles, read 0x41 -> 16'h0000; write 16'h0003 -> eoc_out resumes with channel_out frozen.
REQ-038 Without macro: write 0x41 = 16'h0000 -> drdy_out returned, eoc_out continues, read 0x41 -> 16'h0001.
REQ-039 clr_n pulsed low one cycle after den_in -> no drdy_out; outputs at reset values; read 0x55 after release -> 16'h0000.

Source files
------------

// File: rtl/drp_sample_responder.sv
// DRP responder exposing two sampled aux channels plus a control register.
// Define DRP_SAMPLE_RESPONDER_WRITE_EN to let DRP writes to 0x41 set seq_en/hold.
module drp_sample_responder #(
  parameter int CONV_PERIOD  = 64,
  parameter int DRDY_LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        den_in,
  input  logic [6:0]  daddr_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  input  logic [11:0] aux0_code,
  input  logic [11:0] aux1_code,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        eoc_out,
  output logic [4:0]  channel_out,
  output logic        busy_out
);

  localparam int TW = $clog2(CONV_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(CONV_PERIOD - 1);
  localparam logic [3:0] L_INIT = 4'(DRDY_LATENCY - 1);

`ifdef DRP_SAMPLE_RESPONDER_WRITE_EN
  localparam logic W_EN = 1'b1;
`else
  localparam logic W_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [4:0]      r_ch;
  logic [15:0]     r_reg10;
  logic [15:0]     r_reg11;
  logic            r_seq_en;
  logic            r_hold;
  logic [3:0]      r_cnt;
  logic [15:0]     r_rd;
  logic [6:0]      r_addr;
  logic            r_dwe;
  logic [1:0]      r_wbits;
  logic            w_eoc;
  logic [15:0]     w_rdata;
  logic            w_unused_di;

  assign w_unused_di = ^di_in[15:2];
  assign w_eoc = r_seq_en && (r_timer == T_LAST);

  always_comb begin
    w_rdata = 16'h0000;
    unique case (1'b1)
      (daddr_in == 7'h10): w_rdata = r_reg10;
      (daddr_in == 7'h11): w_rdata = r_reg11;
      (daddr_in == 7'h41): w_rdata = {14'h0, r_hold, r_seq_en};
      default:             w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_timer     <= '0;
      eoc_out     <= 1'b0;
      r_ch        <= 5'h10;
      channel_out <= 5'h10;
      r_reg10     <= 16'h0000;
      r_reg11     <= 16'h0000;
    end else begin
      eoc_out <= w_eoc;
      if (r_seq_en)
        r_timer <= w_eoc ? '0 : r_timer + 1'b1;
      if (w_eoc) begin
        channel_out <= r_ch;
        if (r_ch == 5'h10)
          r_reg10 <= {aux0_code, 4'h0};
        else
          r_reg11 <= {aux1_code, 4'h0};
        if (!r_hold)
          r_ch <= r_ch ^ 5'h01;
      end
    end
  end

  // Read data is snapshot at acceptance, so a same-edge capture is not seen.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_rd     <= 16'h0000;
      r_addr   <= 7'h00;
      r_dwe    <= 1'b0;
      r_wbits  <= 2'b00;
      do_out   <= 16'h0000;
      drdy_out <= 1'b0;
      busy_out <= 1'b0;
      r_seq_en <= 1'b1;
      r_hold   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          drdy_out <= 1'b0;
          do_out   <= 16'h0000;
          if (den_in) begin
            r_state  <= S_WAIT;
            r_addr   <= daddr_in;
            r_dwe    <= dwe_in;
            r_wbits  <= di_in[1:0];
            r_rd     <= dwe_in ? 16'h0000 : w_rdata;
            r_cnt    <= L_INIT;
            busy_out <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_RESP;
            drdy_out <= 1'b1;
            do_out   <= r_rd;
            if (W_EN && r_dwe && (r_addr == 7'h41))
              {r_hold, r_seq_en} <= r_wbits;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          drdy_out <= 1'b0;
          do_out   <= 16'h0000;
          busy_out <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
